// File: rtl/motor_step_if.sv
// Command/status bundle between a motion controller and motor_step_ctrl.
// The controller side drives the command and abort; the stepper side returns coil phase and status.
interface motor_step_if #(
    parameter int unsigned CW = 8,
    parameter int unsigned PW = 8
);
    logic          start;
    logic          dir;
    logic [CW-1:0] steps;
    logic [CW-1:0] period;
    logic          abort;
    logic [2:0]    phase;
    logic          busy;
    logic          done;
    logic [PW-1:0] pos;

    modport master (
        output start, dir, steps, period, abort,
        input  phase, busy, done, pos
    );

    modport slave (
        input  start, dir, steps, period, abort,
        output phase, busy, done, pos
    );
endinterface

// File: rtl/motor_step_ctrl.sv
// Six-beat stepper sequencer: issues a latched number of steps at a fixed period,
// tracks a wrapping signed position and supports abort.
module motor_step_ctrl #(
    parameter int unsigned CW = 8,
    parameter int unsigned PW = 8
) (
    input  logic          CP,
    input  logic          CR,
    motor_step_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] PHASE_HOME = 3'b100;

    state_e        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] reload_q, reload_d;
    logic          dir_q, dir_d;
    logic [2:0]    phase_q, phase_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] start_reload;

    // One position along the coil ring; anything off the ring re-enters at home.
    function automatic logic [2:0] next_phase(input logic [2:0] cur, input logic fwd);
        logic [2:0] nxt;
        nxt = PHASE_HOME;
        case (cur)
            3'b100:  nxt = fwd ? 3'b101 : 3'b110;
            3'b101:  nxt = fwd ? 3'b001 : 3'b100;
            3'b001:  nxt = fwd ? 3'b011 : 3'b101;
            3'b011:  nxt = fwd ? 3'b010 : 3'b001;
            3'b010:  nxt = fwd ? 3'b110 : 3'b011;
            3'b110:  nxt = fwd ? 3'b100 : 3'b010;
            default: nxt = PHASE_HOME;
        endcase
        return nxt;
    endfunction

    // A period of 0 runs as a period of 1.
    assign start_reload = (bus.period == '0) ? '0 : bus.period - CW'(1);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tmr_d    = tmr_q;
        reload_d = reload_q;
        dir_d    = dir_q;
        phase_d  = phase_q;
        pos_d    = pos_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dir_d    = bus.dir;
                    rem_d    = bus.steps;
                    tmr_d    = start_reload;
                    reload_d = start_reload;
                    state_d  = (bus.steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (tmr_q != '0) begin
                    tmr_d = tmr_q - CW'(1);
                end else begin
                    phase_d = next_phase(phase_q, dir_q);
                    rem_d   = rem_q - CW'(1);
                    pos_d   = dir_q ? pos_q + PW'(1) : pos_q - PW'(1);
                    tmr_d   = reload_q;
                    if (rem_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            tmr_q    <= '0;
            reload_q <= '0;
            dir_q    <= 1'b0;
            phase_q  <= PHASE_HOME;
            pos_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            tmr_q    <= tmr_d;
            reload_q <= reload_d;
            dir_q    <= dir_d;
            phase_q  <= phase_d;
            pos_q    <= pos_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.phase = phase_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.pos   = pos_q;

endmodule
